merge_sort_sched: RTL and testbench

- Block-level scheduler for the 8-element merge sort engine.
- Accepts a byte stream on a valid/ready input and packs every 8 bytes into one block.
- For each block: presents the packed block to the sorter, pulses its start, collects the serial sorted result, then streams the result out with valid/ready and a last marker.
- Sits between the BWT front-end byte stream and the sorter instance; one block in flight at a time.

---
 rtl/merge_sort_sched.sv | 163 ++++++++++++++++
 tb/tb_merge_sort_sched.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_sort_sched.sv
// Block scheduler for the merge sort engine: packs input bytes into blocks, kicks the sorter,
// collects its serial result and streams it out. MERGE_SORT_ORDER_CHECK_EN adds the sort_err flag.
module merge_sort_sched #(
    parameter int ELEMENT_NUM = 8,
    parameter int ELEMENT_LEN = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ELEMENT_LEN-1:0]             in_data,
    output logic                               sort_start,
    output logic [ELEMENT_NUM*ELEMENT_LEN-1:0] sort_data,
    input  logic                               sort_res_valid,
    input  logic [ELEMENT_LEN-1:0]             sort_res_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ELEMENT_LEN-1:0]             out_data,
    output logic                               out_last,
    output logic                               busy,
    output logic                               err_timeout,
    input  logic                               clr_err
`ifdef MERGE_SORT_ORDER_CHECK_EN
    ,
    output logic                               sort_err
`endif
);

    localparam int IW = $clog2(ELEMENT_NUM);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [IW-1:0] LAST_IDX = IW'(ELEMENT_NUM - 1);
    // Fire on the cycle the counter would reach TIMEOUT_CYC-1.
    localparam logic [TW-1:0] TO_FIRE  = TW'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        KICK    = 2'd1,
        COLLECT = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                 state;
    logic [ELEMENT_LEN-1:0] in_buf  [ELEMENT_NUM];
    logic [ELEMENT_LEN-1:0] res_buf [ELEMENT_NUM];
    logic [IW-1:0]          wr_idx;
    logic [IW-1:0]          rd_idx;
    logic [IW-1:0]          out_idx;
    logic [TW-1:0]          tcnt;
    logic                   timeout_fire;

    assign timeout_fire = (state == COLLECT) && !sort_res_valid && (tcnt == TO_FIRE);

    assign in_ready   = (state == FILL);
    assign sort_start = (state == KICK);
    assign busy       = (state != FILL);
    assign out_valid  = (state == DRAIN);
    assign out_data   = res_buf[out_idx];
    assign out_last   = (state == DRAIN) && (out_idx == LAST_IDX);

    // in_buf is only written in FILL, so sort_data is stable from KICK until FILL.
    generate
        for (genvar gi = 0; gi < ELEMENT_NUM; gi++) begin : g_pack
            assign sort_data[gi*ELEMENT_LEN +: ELEMENT_LEN] = in_buf[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FILL;
            wr_idx      <= '0;
            rd_idx      <= '0;
            out_idx     <= '0;
            tcnt        <= '0;
            err_timeout <= 1'b0;
            for (int i = 0; i < ELEMENT_NUM; i++) begin
                in_buf[i]  <= '0;
                res_buf[i] <= '0;
            end
        end else begin
            if (timeout_fire) begin
                err_timeout <= 1'b1;
            end else if (clr_err) begin
                err_timeout <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (in_valid) begin
                        in_buf[wr_idx] <= in_data;
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            state  <= KICK;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                KICK: begin
                    tcnt  <= '0;
                    state <= COLLECT;
                end
                COLLECT: begin
                    // A result element in the same cycle as the timeout wins.
                    if (sort_res_valid) begin
                        res_buf[rd_idx] <= sort_res_data;
                        tcnt            <= '0;
                        if (rd_idx == LAST_IDX) begin
                            rd_idx <= '0;
                            state  <= DRAIN;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end else if (timeout_fire) begin
                        tcnt    <= '0;
                        rd_idx  <= '0;
                        wr_idx  <= '0;
                        out_idx <= '0;
                        state   <= FILL;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_idx == LAST_IDX) begin
                            out_idx <= '0;
                            state   <= FILL;
                        end else begin
                            out_idx <= out_idx + IW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef MERGE_SORT_ORDER_CHECK_EN
    logic [ELEMENT_LEN-1:0] prev_res;
    logic                   order_bad;

    assign order_bad = (state == COLLECT) && sort_res_valid && (rd_idx != '0)
                       && (sort_res_data < prev_res);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_res <= '0;
            sort_err <= 1'b0;
        end else begin
            if (state == COLLECT && sort_res_valid) begin
                prev_res <= sort_res_data;
            end
            if (order_bad) begin
                sort_err <= 1'b1;
            end else if (clr_err) begin
                sort_err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_merge_sort_sched.sv
// Self-checking bench for merge_sort_sched: random blocks against a sorted-queue reference,
// plus directed backpressure, timeout, spurious-result, reset and order-check scenarios.
`timescale 1ns/1ps
module tb_merge_sort_sched;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         sort_start;
    logic [N*W-1:0] sort_data;
    logic         sort_res_valid = 1'b0;
    logic [W-1:0] sort_res_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         err_timeout;
    logic         clr_err = 1'b0;
`ifdef MERGE_SORT_ORDER_CHECK_EN
    logic         sort_err;
`endif

    always #5 clk = ~clk;

    merge_sort_sched #(.ELEMENT_NUM(N), .ELEMENT_LEN(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sort_start(sort_start), .sort_data(sort_data),
        .sort_res_valid(sort_res_valid), .sort_res_data(sort_res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout), .clr_err(clr_err)
`ifdef MERGE_SORT_ORDER_CHECK_EN
        , .sort_err(sort_err)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int blk_no = 0;

    logic [W-1:0]   stim [N];
    logic [W-1:0]   expq [$];
    logic [W-1:0]   sq   [$];
    logic [W-1:0]   got  [$];
    logic           got_last [$];
    logic [N*W-1:0] obs_sd;
    logic           obs_start_kick, obs_start_after, obs_inrdy_kick;
    int             ready_viol, start_early, hold_viol, inrdy_viol;
    logic           post_inrdy, post_busy;

    // Reference: ascending order of the block, built by value scan.
    task automatic build_exp();
        expq.delete();
        for (int v = 0; v < 256; v++)
            for (int i = 0; i < N; i++)
                if (int'(stim[i]) == v) expq.push_back(stim[i]);
    endtask

    // Sorter model: sorts whatever the DUT presents on sort_data.
    task automatic build_sq();
        sq.delete();
        for (int v = 0; v < 256; v++)
            for (int i = 0; i < N; i++)
                if (int'(obs_sd[i*W +: W]) == v) sq.push_back(obs_sd[i*W +: W]);
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic feed_block(input int gapmax);
        ready_viol = 0; start_early = 0;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(gapmax, 0)) begin
                in_valid = 1'b0;
                @(posedge clk); @(negedge clk);
            end
            in_valid = 1'b1; in_data = stim[i];
            if (in_ready !== 1'b1) ready_viol++;
            if (sort_start !== 1'b0) start_early++;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        obs_start_kick = sort_start;
        obs_inrdy_kick = in_ready;
        obs_sd         = sort_data;
        @(posedge clk); @(negedge clk);
        obs_start_after = sort_start;
    endtask

    task automatic sorter_respond(input int n, input int gapmax);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gapmax, 0)) begin @(posedge clk); @(negedge clk); end
            sort_res_valid = 1'b1; sort_res_data = sq.pop_front();
            @(posedge clk); @(negedge clk);
            sort_res_valid = 1'b0;
        end
    endtask

    task automatic drain(input bit bp);
        int   cyc = 0;
        logic stalled = 1'b0;
        logic [W-1:0] held = '0;
        got.delete(); got_last.delete(); hold_viol = 0; inrdy_viol = 0;
        while (cyc < 100) begin
            out_ready = bp ? ((cyc % 2) == 0) : 1'b1;
            if (!out_valid) break;
            if (stalled && out_data !== held) hold_viol++;
            if (in_ready !== 1'b0) inrdy_viol++;
            if (out_ready) begin
                got.push_back(out_data); got_last.push_back(out_last); stalled = 1'b0;
            end else begin
                stalled = 1'b1; held = out_data;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        out_ready  = 1'b0;
        post_inrdy = in_ready;
        post_busy  = busy;
        blk_no++;
        $display("block %0d: drained %0d elements in %0d cycles", blk_no, got.size(), cyc);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({in_ready, busy, sort_start, out_valid, out_last, err_timeout} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_outputs got %b want 100000",
                {in_ready, busy, sort_start, out_valid, out_last, err_timeout});
        end
        n_cmp++; if (sort_data !== '0) begin
            n_fail++; $display("FAIL reset_sort_data got %h want 0", sort_data);
        end
`ifdef MERGE_SORT_ORDER_CHECK_EN
        n_cmp++; if (sort_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_sort_err got %b want 0", sort_err);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [N*W-1:0] exp_sd;
        stim = '{8'h37, 8'h05, 8'hFF, 8'h00, 8'h12, 8'h12, 8'h80, 8'h01};
        build_exp();
        for (int i = 0; i < N; i++) exp_sd[i*W +: W] = stim[i];
        feed_block(0);
        n_cmp++; if (ready_viol != 0 || start_early != 0) begin
            n_fail++; $display("FAIL basic_fill got ready_viol=%0d start_early=%0d want 0/0", ready_viol, start_early);
        end
        n_cmp++; if ({obs_start_kick, obs_start_after, obs_inrdy_kick} !== 3'b100) begin
            n_fail++; $display("FAIL basic_kick got start=%b,%b in_ready=%b want 1,0 0",
                obs_start_kick, obs_start_after, obs_inrdy_kick);
        end
        n_cmp++; if (obs_sd !== exp_sd) begin
            n_fail++; $display("FAIL basic_sort_data got %h want %h", obs_sd, exp_sd);
        end
        build_sq();
        sorter_respond(N, 0);
        drain(1'b0);
        n_cmp++; if (got.size() != N) begin
            n_fail++; $display("FAIL basic_count got %0d want %0d", got.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_cmp++; if ({got_last[i], got[i]} !== {1'(i == N-1), expq[i]}) begin
                    n_fail++; $display("FAIL basic_out[%0d] got last=%b data=%h want last=%b data=%h",
                        i, got_last[i], got[i], i == N-1, expq[i]);
                end
            end
        end
        n_cmp++; if ({post_inrdy, post_busy, err_timeout} !== 3'b100) begin
            n_fail++; $display("FAIL basic_end got in_ready=%b busy=%b err=%b want 1 0 0",
                post_inrdy, post_busy, err_timeout);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
        build_exp();
        feed_block(0);
        build_sq();
        sorter_respond(N, 2);
        drain(1'b1);
        n_cmp++; if (hold_viol != 0 || inrdy_viol != 0) begin
            n_fail++; $display("FAIL bp_hold got hold_viol=%0d in_ready_viol=%0d want 0/0", hold_viol, inrdy_viol);
        end
        n_cmp++; if (got.size() != N) begin
            n_fail++; $display("FAIL bp_count got %0d want %0d", got.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_cmp++; if ({got_last[i], got[i]} !== {1'(i == N-1), expq[i]}) begin
                    n_fail++; $display("FAIL bp_out[%0d] got last=%b data=%h want last=%b data=%h",
                        i, got_last[i], got[i], i == N-1, expq[i]);
                end
            end
        end
        n_cmp++; if (post_inrdy !== 1'b1) begin
            n_fail++; $display("FAIL bp_in_ready_after got %b want 1", post_inrdy);
        end
    endtask

    task automatic test_timeout();
        int early = 0;
        for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
        feed_block(0);
        build_sq();
        sorter_respond(3, 0);
        sq.delete();
        for (int k = 1; k < TO - 1; k++) begin
            @(posedge clk); @(negedge clk);
            if (err_timeout !== 1'b0) early++;
        end
        n_cmp++; if (early != 0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early got early=%0d in_ready=%b want 0 0", early, in_ready);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({err_timeout, in_ready, busy} !== 3'b110) begin
            n_fail++; $display("FAIL timeout_fire got err=%b in_ready=%b busy=%b want 1 1 0",
                err_timeout, in_ready, busy);
        end
        clr_err = 1'b1;
        @(posedge clk); @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear got %b want 0", err_timeout);
        end
        blk_no++;
        $display("block %0d: timed out after 3 results", blk_no);
    endtask

    task automatic test_spurious();
        int aa_seen = 0;
        sort_res_valid = 1'b1; sort_res_data = 8'hAA;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        sort_res_valid = 1'b0;
        n_cmp++; if ({in_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL spurious_state got in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        for (int i = 0; i < N; i++) begin
            stim[i] = 8'($urandom);
            if (stim[i] == 8'hAA) stim[i] = 8'hAB;
        end
        build_exp();
        feed_block(1);
        build_sq();
        sorter_respond(N, 1);
        drain(1'b0);
        foreach (got[i]) if (got[i] == 8'hAA) aa_seen++;
        n_cmp++; if (got.size() != N || aa_seen != 0) begin
            n_fail++; $display("FAIL spurious_count got %0d elems, %0d AA want %0d elems, 0 AA",
                got.size(), aa_seen, N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_cmp++; if ({got_last[i], got[i]} !== {1'(i == N-1), expq[i]}) begin
                    n_fail++; $display("FAIL spurious_out[%0d] got last=%b data=%h want last=%b data=%h",
                        i, got_last[i], got[i], i == N-1, expq[i]);
                end
            end
        end
    endtask

    task automatic test_reset_collect();
        for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
        feed_block(0);
        build_sq();
        sorter_respond(4, 0);
        rst = 1'b0;
        #1;
        n_cmp++; if ({in_ready, busy, sort_start, out_valid, out_last, err_timeout} !== 6'b100000) begin
            n_fail++; $display("FAIL rstmid_outputs got %b want 100000",
                {in_ready, busy, sort_start, out_valid, out_last, err_timeout});
        end
        n_cmp++; if (sort_data !== '0) begin
            n_fail++; $display("FAIL rstmid_sort_data got %h want 0", sort_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_out_valid got %b want 0", out_valid);
        end
        blk_no++;
        $display("block %0d: aborted by reset", blk_no);
        for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
        build_exp();
        feed_block(0);
        build_sq();
        sorter_respond(N, 0);
        drain(1'b0);
        n_cmp++; if (got.size() != N) begin
            n_fail++; $display("FAIL rstmid_count got %0d want %0d", got.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_cmp++; if ({got_last[i], got[i]} !== {1'(i == N-1), expq[i]}) begin
                    n_fail++; $display("FAIL rstmid_out[%0d] got last=%b data=%h want last=%b data=%h",
                        i, got_last[i], got[i], i == N-1, expq[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
            build_exp();
            feed_block(2);
            build_sq();
            sorter_respond(N, 3);
            drain(1'($urandom_range(1, 0)));
            n_cmp++; if (got.size() != N || hold_viol != 0) begin
                n_fail++; $display("FAIL rand%0d_count got %0d elems hold_viol=%0d want %0d 0",
                    b, got.size(), hold_viol, N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    n_cmp++; if ({got_last[i], got[i]} !== {1'(i == N-1), expq[i]}) begin
                        n_fail++; $display("FAIL rand%0d_out[%0d] got last=%b data=%h want last=%b data=%h",
                            b, i, got_last[i], got[i], i == N-1, expq[i]);
                    end
                end
            end
            n_cmp++; if (err_timeout !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_err got %b want 0", b, err_timeout);
            end
        end
    endtask

`ifdef MERGE_SORT_ORDER_CHECK_EN
    task automatic test_order_check();
        for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
        feed_block(0);
        sq   = '{8'h01, 8'h03, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expq = '{8'h01, 8'h03, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        sorter_respond(2, 0);
        n_cmp++; if (sort_err !== 1'b0) begin
            n_fail++; $display("FAIL order_before got %b want 0", sort_err);
        end
        sorter_respond(1, 0);
        n_cmp++; if (sort_err !== 1'b1) begin
            n_fail++; $display("FAIL order_set got %b want 1", sort_err);
        end
        sorter_respond(N - 3, 0);
        drain(1'b0);
        n_cmp++; if (got.size() != N) begin
            n_fail++; $display("FAIL order_count got %0d want %0d", got.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_cmp++; if ({got_last[i], got[i]} !== {1'(i == N-1), expq[i]}) begin
                    n_fail++; $display("FAIL order_out[%0d] got last=%b data=%h want last=%b data=%h",
                        i, got_last[i], got[i], i == N-1, expq[i]);
                end
            end
        end
        clr_err = 1'b1;
        @(posedge clk); @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (sort_err !== 1'b0) begin
            n_fail++; $display("FAIL order_clear got %b want 0", sort_err);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_spurious();
        test_reset_collect();
        test_random();
`ifdef MERGE_SORT_ORDER_CHECK_EN
        test_order_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
